waitstate_memory: RTL

WAITSTATE_MEMORY -- requirements
Module: waitstate_memory

---
 rtl/memory_pkg.sv | 26 ++
 rtl/bytewise_ram.sv | 39 +++
 rtl/waitstate_memory.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | memory_pkg : shared FSM state type and address-width helpers    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package memory_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bo_width(input int data_w);
        return (data_w > BYTE_W) ? $clog2(data_w / BYTE_W) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bytewise_ram.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bytewise_ram : word array with per-byte-lane write, async read  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module bytewise_ram
    import memory_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              DEPTH      = 64,
    parameter logic [DATA_W-1:0] INIT_WORD0 = 32'h00A11822,
    localparam int             ADDR_W     = addr_width(DEPTH),
    localparam int             NB         = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [NB-1:0]     be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Power-up image only; no reset path touches the array.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{0: INIT_WORD0, default: '0};

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/waitstate_memory.sv
`default_nettype none
// +----------------------------------------------------------------+
// | waitstate_memory : byte-addressed memory with programmable wait |
// | states, alignment/range error response. Rev 1.0                 |
// +----------------------------------------------------------------+
module waitstate_memory
    import memory_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 64,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] INIT_WORD0  = 32'h00A11822,
    localparam int               ADDR_W      = addr_width(DEPTH),
    localparam int               BO_W        = bo_width(DATA_W),
    localparam int               NB          = DATA_W / BYTE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W+BO_W-1:0] addr,
    input  logic [NB-1:0]          be,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic                   busy,
    output logic                   err
);

    localparam logic [CNT_W-1:0] WAIT_INIT = WAIT_CYCLES[CNT_W-1:0];
    localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [31:0]      DEPTH_W   = 32'(DEPTH);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [ADDR_W-1:0]  word_q;
    logic [NB-1:0]      be_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               ready_q;
    logic               busy_q;
    logic               err_q;

    logic [ADDR_W-1:0]  w_word_idx;
    logic               w_misaligned;
    logic               w_in_range;
    logic               w_access;
    logic               w_acc_we;
    logic [ADDR_W-1:0]  w_acc_word;
    logic [NB-1:0]      w_acc_be;
    logic [DATA_W-1:0]  w_acc_wdata;
    logic [DATA_W-1:0]  w_ram_rdata;
    logic               w_wr_en;

    assign w_word_idx = addr[ADDR_W+BO_W-1:BO_W];
    assign w_in_range = (32'(w_word_idx) < DEPTH_W);

    generate
        if (BO_W > 0) begin : g_bo_check
            assign w_misaligned = |addr[(BO_W > 0 ? BO_W : 1)-1:0];
        end else begin : g_bo_none
            assign w_misaligned = 1'b0;
        end
    endgenerate

    // A zero-wait access uses the live inputs on the accept edge; otherwise the captured copy.
    assign w_access    = (state_q == IDLE) ? (ZERO_WAIT && req && !w_misaligned && w_in_range)
                                           : ((state_q == WAIT) && (cnt_q == 4'd1));
    assign w_acc_we    = (state_q == IDLE) ? we         : we_q;
    assign w_acc_word  = (state_q == IDLE) ? w_word_idx : word_q;
    assign w_acc_be    = (state_q == IDLE) ? be         : be_q;
    assign w_acc_wdata = (state_q == IDLE) ? wdata      : wdata_q;
    assign w_wr_en     = !rst && w_access && w_acc_we;

    bytewise_ram #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .INIT_WORD0 (INIT_WORD0)
    ) u_ram (
        .clk     (clk),
        .wr_en_i (w_wr_en),
        .addr_i  (w_acc_word),
        .be_i    (w_acc_be),
        .wdata_i (w_acc_wdata),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        word_q  <= w_word_idx;
                        be_q    <= be;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (w_misaligned || !w_in_range) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (ZERO_WAIT) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            if (!we) begin
                                rdata_q <= w_ram_rdata;
                            end
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= w_ram_rdata;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule
`default_nettype wire
